alu_cond_exec: RTL

Execute-stage consumer of the ALU decoder outputs in the pipelined processor. It performs the ALU operation selected by ALUControl and evaluates the instruction's Cond field against the architectural NZCV flags. It updates those flags under FlagW and registers the result and gated control signals into the Memory stage. It is the receiving end of the ALUControl/FlagW interface.

---
 rtl/alu_cond_exec.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/alu_cond_exec.sv
`default_nettype none
// ============================================================================
// Module   : alu_cond_exec
// Purpose  : Execute-stage ALU with NZCV condition evaluation, flag update
//            and E->M pipeline register with condition-gated write enables.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cond_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             flush,
    input  logic             valid_e,
    input  logic [1:0]       ALUControl,
    input  logic [1:0]       FlagW,
    input  logic [3:0]       Cond,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             PCS_e,
    input  logic             RegW_e,
    input  logic             MemW_e,
    output logic             CondEx_e,
    output logic [3:0]       Flags,
    output logic [WIDTH-1:0] ALUResult_m,
    output logic             PCSrc_m,
    output logic             RegWrite_m,
    output logic             MemWrite_m,
    output logic             valid_m
);

    localparam int c_MSB = WIDTH - 1;

    // Reset asserts asynchronously; release is retimed to clk so no flop
    // sees a deassertion edge close to its clock.
    logic [1:0] r_rst_sync;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // ALU: add and sub share one adder; sub is A + ~B + 1.
    logic [WIDTH-1:0] w_b_op;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_result;
    logic             w_n;
    logic             w_z;
    logic             w_c;
    logic             w_v;

    assign w_b_op = ALUControl[0] ? ~SrcB : SrcB;
    assign w_sum  = {1'b0, SrcA} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, ALUControl[0]};

    always_comb begin
        w_result = '0;
        w_c      = 1'b0;
        w_v      = 1'b0;
        case (ALUControl)
            2'b00, 2'b01: begin
                w_result = w_sum[c_MSB:0];
                w_c      = w_sum[WIDTH];
                w_v      = (SrcA[c_MSB] == w_b_op[c_MSB]) && (w_sum[c_MSB] != SrcA[c_MSB]);
            end
            2'b10:   w_result = SrcA & SrcB;
            2'b11:   w_result = SrcA | SrcB;
            default: w_result = '0;
        endcase
        w_n = w_result[c_MSB];
        w_z = (w_result == '0);
    end

    // Condition check looks only at architectural (registered) flags.
    logic w_fn;
    logic w_fz;
    logic w_fc;
    logic w_fv;
    logic w_cond_pass;

    assign {w_fn, w_fz, w_fc, w_fv} = Flags;

    always_comb begin
        w_cond_pass = 1'b1;
        case (Cond)
            4'b0000: w_cond_pass = w_fz;
            4'b0001: w_cond_pass = !w_fz;
            4'b0010: w_cond_pass = w_fc;
            4'b0011: w_cond_pass = !w_fc;
            4'b0100: w_cond_pass = w_fn;
            4'b0101: w_cond_pass = !w_fn;
            4'b0110: w_cond_pass = w_fv;
            4'b0111: w_cond_pass = !w_fv;
            4'b1000: w_cond_pass = w_fc && !w_fz;
            4'b1001: w_cond_pass = !w_fc || w_fz;
            4'b1010: w_cond_pass = (w_fn == w_fv);
            4'b1011: w_cond_pass = (w_fn != w_fv);
            4'b1100: w_cond_pass = !w_fz && (w_fn == w_fv);
            4'b1101: w_cond_pass = w_fz || (w_fn != w_fv);
            default: w_cond_pass = 1'b1;
        endcase
    end

    assign CondEx_e = valid_e && w_cond_pass && !flush;

    // CondEx_e already excludes flushed instructions, so flush blocks flag writes.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            Flags <= 4'b0000;
        end else if (CondEx_e && !stall) begin
            if (FlagW[1]) begin
                Flags[3:2] <= {w_n, w_z};
            end
            if (FlagW[0]) begin
                Flags[1:0] <= {w_c, w_v};
            end
        end
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            ALUResult_m <= '0;
            PCSrc_m     <= 1'b0;
            RegWrite_m  <= 1'b0;
            MemWrite_m  <= 1'b0;
            valid_m     <= 1'b0;
        end else if (flush) begin
            PCSrc_m     <= 1'b0;
            RegWrite_m  <= 1'b0;
            MemWrite_m  <= 1'b0;
            valid_m     <= 1'b0;
        end else if (!stall) begin
            ALUResult_m <= w_result;
            PCSrc_m     <= PCS_e && CondEx_e;
            RegWrite_m  <= RegW_e && CondEx_e;
            MemWrite_m  <= MemW_e && CondEx_e;
            valid_m     <= valid_e;
        end
    end

endmodule
`default_nettype wire
